// File: rtl/usbf_cdc_rx_port_pkg.sv
// Shared types and defaults for the destination-side USB-function CDC port.
package usbf_cdc_rx_port_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } cdc_state_e;

   localparam int unsigned USBF_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/usbf_cdc_rx_port_sync_chain.sv
// W-bit multi-flop synchroniser chain with synchronous active-high reset.
module usbf_sync_chain
   import usbf_cdc_rx_port_pkg::*;
#(
   parameter int unsigned STAGES = USBF_SYNC_STAGES_DEF,
   parameter int unsigned W      = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [STAGES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/usbf_cdc_rx_port.sv
// Receive half of the USB-function CDC: synchronised control channels plus a
// req/ack toggle handshake that delivers bus words with valid/ready back-pressure.
module usbf_cdc_rx_port
   import usbf_cdc_rx_port_pkg::*;
#(
   parameter int unsigned       CH_NUM      = 4,
   parameter int unsigned       SYNC_STAGES = USBF_SYNC_STAGES_DEF,
   parameter logic [CH_NUM-1:0] PULSE_MASK  = '1,
   parameter int unsigned       BUS_W       = 16,
   parameter logic [BUS_W-1:0]  BUS_RST     = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CH_NUM-1:0] async_ch_i,
   output logic [CH_NUM-1:0] ch_o,
   output logic              ch_any_o,
   input  logic              async_req_tgl_i,
   input  logic [BUS_W-1:0]  async_bus_i,
   output logic              ack_tgl_o,
   output logic              bus_valid_o,
   input  logic              bus_ready_i,
   output logic [BUS_W-1:0]  bus_data_o,
   output logic              bus_busy_o
);

   logic [CH_NUM-1:0] ch_s;
   logic [CH_NUM-1:0] ch_prev_q;
   logic [CH_NUM-1:0] ch_pulse_q, ch_pulse_d;
   logic              req_s;

   cdc_state_e        state_q, state_d;
   logic [BUS_W-1:0]  data_q, data_d;
   logic              seen_q, seen_d;
   logic              ack_q, ack_d;

   usbf_sync_chain #(
      .STAGES (SYNC_STAGES),
      .W      (CH_NUM)
   ) u_ch_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (async_ch_i),
      .q_o   (ch_s)
   );

   usbf_sync_chain #(
      .STAGES (SYNC_STAGES),
      .W      (1)
   ) u_req_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (async_req_tgl_i),
      .q_o   (req_s)
   );

   // Pulse channels get one extra registered edge-detect stage; level channels tap the chain directly.
   assign ch_pulse_d = (ch_s ^ ch_prev_q) & PULSE_MASK;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ch_prev_q  <= '0;
         ch_pulse_q <= '0;
      end else begin
         ch_prev_q  <= ch_s;
         ch_pulse_q <= ch_pulse_d;
      end
   end

   assign ch_o     = (ch_s & ~PULSE_MASK) | ch_pulse_q;
   assign ch_any_o = |(ch_o & PULSE_MASK);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= BUS_RST;
         seen_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         seen_q  <= seen_d;
         ack_q   <= ack_d;
      end
   end

   // async_bus_i is only sampled once req_s shows a new toggle, so the source holds it stable.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      seen_d  = seen_q;
      ack_d   = ack_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s != seen_q) begin
               data_d  = async_bus_i;
               seen_d  = req_s;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus_ready_i) begin
               ack_d   = seen_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus_valid_o = (state_q == ST_HOLD);
   assign bus_busy_o  = (state_q == ST_HOLD);
   assign bus_data_o  = data_q;
   assign ack_tgl_o   = ack_q;

endmodule

// File: tb/tb_usbf_cdc_rx_port.sv
// Self-checking bench for usbf_cdc_rx_port: directed latency cases plus random traffic against a history/scoreboard model.
module tb_usbf_cdc_rx_port;

   localparam int unsigned   CH_NUM = 4;
   localparam int unsigned   BUS_W  = 16;
   localparam logic [3:0]    MASK   = 4'b0101;
   localparam logic [15:0]   RSTV   = 16'h0F0F;
   localparam int            HN     = 16384;

   logic              clk;
   logic              rst_i;
   logic [CH_NUM-1:0] async_ch_i;
   logic [CH_NUM-1:0] ch_o;
   logic              ch_any_o;
   logic              async_req_tgl_i;
   logic [BUS_W-1:0]  async_bus_i;
   logic              ack_tgl_o;
   logic              bus_valid_o;
   logic              bus_ready_i;
   logic [BUS_W-1:0]  bus_data_o;
   logic              bus_busy_o;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 100;
   bit          mon_en = 0;
   bit          done = 0;
   logic        req_q = 1'b0;
   logic [15:0] exp_q [$];
   logic [3:0]  hist [HN];

   usbf_cdc_rx_port #(
      .CH_NUM      (CH_NUM),
      .SYNC_STAGES (2),
      .PULSE_MASK  (MASK),
      .BUS_W       (BUS_W),
      .BUS_RST     (RSTV)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .async_ch_i      (async_ch_i),
      .ch_o            (ch_o),
      .ch_any_o        (ch_any_o),
      .async_req_tgl_i (async_req_tgl_i),
      .async_bus_i     (async_bus_i),
      .ack_tgl_o       (ack_tgl_o),
      .bus_valid_o     (bus_valid_o),
      .bus_ready_i     (bus_ready_i),
      .bus_data_o      (bus_data_o),
      .bus_busy_o      (bus_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack();
      for (int k = 0; k < 200 && ack_tgl_o !== req_q; k++) tick();
      chk("ack_wait", ack_tgl_o, req_q);
   endtask

   task automatic send_word(input logic [15:0] w);
      async_bus_i     = w;
      req_q           = ~req_q;
      async_req_tgl_i = req_q;
      exp_q.push_back(w);
      wait_ack();
   endtask

   // Reference: channel i at cycle n is input from n-2 (level) or the change between n-4 and n-3 (pulse);
   // the bus path is a FIFO of sent words, and ack equals parity of accepted words.
   initial begin : monitor
      logic [3:0]  exp_ch;
      logic [15:0] hold_data;
      bit          hold_prev;
      int          acc_cnt;
      hold_prev = 0;
      acc_cnt   = 0;
      hold_data = '0;
      for (int i = 0; i < HN; i++) hist[i] = '0;
      forever begin
         @(negedge clk);
         hist[cyc % HN] = async_ch_i;
         exp_ch = (hist[(cyc-2) % HN] & ~MASK) |
                  ((hist[(cyc-3) % HN] ^ hist[(cyc-4) % HN]) & MASK);
         if (mon_en) begin
            chk("ch_o", ch_o, exp_ch);
            chk("ch_any", ch_any_o, |(exp_ch & MASK));
            chk("ack_parity", ack_tgl_o, acc_cnt % 2);
            chk("busy_eq_valid", bus_busy_o, bus_valid_o);
            if (hold_prev) begin
               chk("hold_valid", bus_valid_o, 1);
               chk("hold_data", bus_data_o, hold_data);
            end
         end
         if (rst_i) begin
            for (int k = 0; k < 4; k++) hist[(cyc-k) % HN] = '0;
            exp_q.delete();
            acc_cnt   = 0;
            hold_prev = 0;
         end else if (bus_valid_o === 1'b1 && bus_ready_i) begin
            if (mon_en) begin
               chk("word_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) chk("word_data", bus_data_o, exp_q.pop_front());
            end
            acc_cnt++;
            hold_prev = 0;
         end else begin
            hold_prev = (bus_valid_o === 1'b1);
            hold_data = bus_data_o;
         end
      end
   end

   initial begin : driver
      rst_i           = 1'b1;
      async_ch_i      = '0;
      async_req_tgl_i = 1'b0;
      async_bus_i     = '0;
      bus_ready_i     = 1'b0;

      // Reset
      tick(3);
      chk("rst_ch_o", ch_o, 0);
      chk("rst_ch_any", ch_any_o, 0);
      chk("rst_ack", ack_tgl_o, 0);
      chk("rst_valid", bus_valid_o, 0);
      chk("rst_busy", bus_busy_o, 0);
      chk("rst_data", bus_data_o, RSTV);
      rst_i  = 1'b0;
      mon_en = 1;
      tick(4);

      // Pulse channel 0: rise at k=0, fall at k=10; pulses expected at k=3 and k=13
      async_ch_i[0] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 10) async_ch_i[0] = 1'b0;
         chk("pulse_ch0", ch_o[0], (k == 3 || k == 13));
         chk("pulse_any", ch_any_o, (k == 3 || k == 13));
      end

      // Level channel 1: high from k=2, never contributes to ch_any
      async_ch_i[1] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("level_ch1", ch_o[1], (k >= 2));
         chk("level_any", ch_any_o, 0);
      end

      // Bus word with ready held high
      bus_ready_i     = 1'b1;
      async_bus_i     = 16'hA5C3;
      req_q           = 1'b1;
      async_req_tgl_i = 1'b1;
      exp_q.push_back(16'hA5C3);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("w1_valid", bus_valid_o, (k == 3));
         if (k == 3) chk("w1_data", bus_data_o, 16'hA5C3);
         chk("w1_ack", ack_tgl_o, (k == 4));
      end

      // Back-pressure
      bus_ready_i     = 1'b0;
      async_bus_i     = 16'h5A5A;
      req_q           = 1'b0;
      async_req_tgl_i = 1'b0;
      exp_q.push_back(16'h5A5A);
      tick(3);
      for (int k = 0; k < 20; k++) begin
         chk("bp_valid", bus_valid_o, 1);
         chk("bp_data", bus_data_o, 16'h5A5A);
         chk("bp_busy", bus_busy_o, 1);
         chk("bp_ack", ack_tgl_o, 1);
         tick();
      end
      bus_ready_i = 1'b1;
      tick();
      chk("bp_release_ack", ack_tgl_o, 0);
      chk("bp_release_valid", bus_valid_o, 0);
      send_word(16'h0001);

      // Random traffic on channels and bus
      fork
         begin
            while (!done) begin
               tick($urandom_range(4, 8));
               async_ch_i = async_ch_i ^ 4'($urandom);
            end
         end
         begin
            while (!done) begin
               bus_ready_i = 1'($urandom_range(0, 1));
               tick();
            end
         end
         begin
            for (int w = 0; w < 30; w++) begin
               tick($urandom_range(0, 3));
               send_word(16'($urandom));
            end
            done = 1;
         end
      join
      tick(2);
      chk("rand_q_empty", exp_q.size(), 0);

      // Reset mid-HOLD with request still high
      bus_ready_i = 1'b1;
      if (req_q) send_word(16'h1234);
      bus_ready_i     = 1'b0;
      async_bus_i     = 16'hBEEF;
      req_q           = 1'b1;
      async_req_tgl_i = 1'b1;
      exp_q.push_back(16'hBEEF);
      tick(3);
      chk("mh_valid", bus_valid_o, 1);
      chk("mh_data", bus_data_o, 16'hBEEF);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("mh_rst_valid", bus_valid_o, 0);
      chk("mh_rst_busy", bus_busy_o, 0);
      chk("mh_rst_ack", ack_tgl_o, 0);
      chk("mh_rst_data", bus_data_o, RSTV);
      exp_q.push_back(16'hBEEF);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("mh_recap_valid", bus_valid_o, (k == 3));
      end
      chk("mh_recap_data", bus_data_o, 16'hBEEF);
      bus_ready_i = 1'b1;
      wait_ack();
      tick(2);
      chk("final_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
